// File: rtl/bundle_encoder.sv
// Streaming HDC bundling encoder: per-dimension majority vote over a delimited frame of binary hypervectors.
// Latency 1 cycle from the closing beat to out_valid; in_ready is low while a result is held (out_ready backpressure).
module bundle_encoder #(
   parameter int DIM      = 64,
   parameter int CNT_W    = 8,
   parameter int TIE_MODE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DIM-1:0]   in_data,
   input  logic             in_last,
   input  logic [DIM-1:0]   tie_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIM-1:0]   out_enc,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);

   localparam logic [CNT_W-1:0] MAXN = {CNT_W{1'b1}};

   typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_n;
   logic [CNT_W-1:0] w_n_nxt;
   logic [CNT_W:0]   w_n_ext;
   logic             w_accept;
   logic             w_force;
   logic             w_close;
   logic [DIM-1:0]   w_tie;
   logic [DIM-1:0]   w_enc_nxt;
   logic [DIM-1:0]   r_enc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   // clr wins over any beat presented in the same cycle
   assign w_accept = in_valid & in_ready & ~clr;
   assign w_n_nxt  = r_n + 1'b1;
   assign w_n_ext  = {1'b0, w_n_nxt};
   assign w_force  = (w_n_nxt == MAXN);
   assign w_close  = w_accept & (in_last | w_force);
   assign w_tie    = (TIE_MODE == 0) ? '0 : (TIE_MODE == 1) ? '1 : tie_vec;

   for (genvar d = 0; d < DIM; d++) begin : g_dim
      logic [CNT_W-1:0] r_acc;
      logic [CNT_W-1:0] w_acc_nxt;
      logic [CNT_W:0]   w_twice;

      // acc never exceeds n, so the CNT_W-bit sum cannot wrap
      assign w_acc_nxt    = r_acc + CNT_W'(in_data[d]);
      assign w_twice      = {w_acc_nxt, 1'b0};
      assign w_enc_nxt[d] = (w_twice > w_n_ext) ? 1'b1 :
                            (w_twice < w_n_ext) ? 1'b0 : w_tie[d];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                r_acc <= '0;
         else if (clr || w_close)   r_acc <= '0;
         else if (w_accept)         r_acc <= w_acc_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_n <= '0;
      else if (clr || w_close)   r_n <= '0;
      else if (w_accept)         r_n <= w_n_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_close) begin
         r_enc <= w_enc_nxt;
         r_cnt <= w_n_nxt;
         r_ovf <= w_force & ~in_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_ACC;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clr) begin
         w_state_nxt = ST_ACC;
      end else begin
         case (r_state)
            ST_ACC:  if (w_close)   w_state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) w_state_nxt = ST_ACC;
            default: w_state_nxt = ST_ACC;
         endcase
      end
   end

   always_comb begin
      in_ready  = (r_state == ST_ACC);
      out_valid = (r_state == ST_OUT);
   end

   assign out_enc = r_enc;
   assign out_cnt = r_cnt;
   assign out_ovf = r_ovf;

endmodule

// File: tb/tb_bundle_encoder.sv
// Bench for bundle_encoder (DIM=8, CNT_W=3, TIE_MODE=2): directed cases plus random frames against a popcount model.
module tb_bundle_encoder;

   localparam int DIM   = 8;
   localparam int CNT_W = 3;
   localparam int MAXN  = 7;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b1;
   logic             clr       = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_last   = 1'b0;
   logic             out_ready = 1'b0;
   logic [DIM-1:0]   in_data   = '0;
   logic [DIM-1:0]   tie_vec   = '0;
   logic             in_ready;
   logic             out_valid;
   logic [DIM-1:0]   out_enc;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;

   int tests = 0;
   int fails = 0;
   logic [7:0] q[$];

   bundle_encoder #(.DIM(DIM), .CNT_W(CNT_W), .TIE_MODE(2)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .tie_vec(tie_vec),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_enc(out_enc), .out_cnt(out_cnt), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Majority per bit over the beats in q, counting ones directly.
   function automatic logic [7:0] model_enc(input logic [7:0] tv);
      logic [7:0] r;
      int ones;
      r = '0;
      for (int d = 0; d < DIM; d++) begin
         ones = 0;
         foreach (q[i]) ones += int'(q[i][d]);
         if (2 * ones > q.size())      r[d] = 1'b1;
         else if (2 * ones < q.size()) r[d] = 1'b0;
         else                          r[d] = tv[d];
      end
      return r;
   endfunction

   task automatic beat(input logic [7:0] d, input logic l);
      chk("in_ready_before_beat", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Sends q as one frame; l_end sets in_last on the final beat.
   task automatic frame(input string tag, input logic l_end, input logic [7:0] tv);
      tie_vec = tv;
      for (int i = 0; i < q.size(); i++) begin
         if (i > 0) chk({tag, "_no_early_valid"}, out_valid, 0);
         beat(q[i], (i == q.size() - 1) && l_end);
      end
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_enc"},   out_enc,   model_enc(tv));
      chk({tag, "_cnt"},   out_cnt,   q.size());
      chk({tag, "_ovf"},   out_ovf,   (q.size() == MAXN) && !l_end);
   endtask

   task automatic take(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_ready_back"}, in_ready,  1);
   endtask

   initial begin
      logic [7:0] e_enc;
      logic [2:0] e_cnt;
      logic       e_ovf;
      logic       l_end;
      int         len;

      #3 rst_n = 1'b0;
      #4;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_enc", out_enc, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_out_ovf", out_ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Majority of three beats
      q = {8'h0F, 8'h33, 8'h55};
      frame("maj", 1'b1, 8'h00);
      chk("maj_enc_const", out_enc, 8'h17);
      take("maj");

      // Tie handling through tie_vec: all-zero, all-one, mixed
      q = {8'hF0, 8'hCC};
      frame("tie0", 1'b1, 8'h00);
      chk("tie0_const", out_enc, 8'hC0);
      take("tie0");
      frame("tie1", 1'b1, 8'hFF);
      chk("tie1_const", out_enc, 8'hFC);
      take("tie1");
      frame("tiev", 1'b1, 8'h0A);
      chk("tiev_const", out_enc, 8'hC8);
      take("tiev");

      // Force close at MAXN without in_last, then a fresh frame starts from 0
      q = {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
      frame("ovf", 1'b0, 8'h00);
      chk("ovf_cnt_const", out_cnt, 7);
      chk("ovf_flag_const", out_ovf, 1);
      take("ovf");
      q = {8'h80};
      frame("after_ovf", 1'b1, 8'h00);
      take("after_ovf");

      // in_last on the MAXN-th beat is a normal close
      q = {8'h03, 8'h03, 8'h03, 8'h01, 8'h00, 8'h00, 8'h02};
      frame("last_at_max", 1'b1, 8'h55);
      take("last_at_max");

      // Backpressure: result held, offered beats ignored
      q = {8'h96, 8'h69, 8'h96};
      frame("bp", 1'b1, 8'h00);
      e_enc = out_enc; e_cnt = out_cnt; e_ovf = out_ovf;
      in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid_hold", out_valid, 1);
         chk("bp_in_ready_low", in_ready, 0);
         chk("bp_enc_stable", out_enc, e_enc);
         chk("bp_cnt_stable", out_cnt, e_cnt);
         chk("bp_ovf_stable", out_ovf, e_ovf);
      end
      take("bp");
      q = {8'h3C};
      frame("after_bp", 1'b1, 8'h00);
      take("after_bp");

      // clr mid-frame discards the beat presented with it
      tie_vec = 8'h00;
      beat(8'hFF, 1'b0);
      beat(8'hFF, 1'b0);
      clr = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
      @(negedge clk);
      clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      chk("clr_no_valid", out_valid, 0);
      q = {8'h00};
      frame("clr", 1'b1, 8'h00);
      chk("clr_enc_const", out_enc, 8'h00);
      chk("clr_cnt_const", out_cnt, 1);

      // clr while holding a result: valid drops, data retained
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_out_valid", out_valid, 0);
      chk("clr_out_in_ready", in_ready, 1);
      chk("clr_out_cnt_kept", out_cnt, 1);

      // Async reset while a result is held
      q = {8'hE1, 8'h1E, 8'hE1};
      frame("prerst", 1'b1, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_cnt", out_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      q = {8'hA5};
      frame("arst", 1'b1, 8'h00);
      chk("arst_enc_const", out_enc, 8'hA5);
      take("arst");

      // Random frames with random tie vectors and backpressure
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, MAXN);
         l_end = (len == MAXN) ? 1'($urandom_range(0, 1)) : 1'b1;
         q = {};
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         frame("rnd", l_end, 8'($urandom));
         e_enc = out_enc;
         for (int c = $urandom_range(0, 3); c > 0; c--) begin
            @(negedge clk);
            chk("rnd_hold_enc", out_enc, e_enc);
         end
         take("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
